// File: rtl/ex_stage_pkg.sv
// Shared constants for the MIPS execute stage: ALU op classes, funct codes,
// ALU control encodings and operand forwarding selects.
package ex_stage_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Code 11 is unused by the hazard unit and falls back to the register value.
  function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                          input logic [31:0] reg_val,
                                          input logic [31:0] mem_val,
                                          input logic [31:0] wb_val);
    case (sel)
      FWD_MEM: fwd_mux = mem_val;
      FWD_WB:  fwd_mux = wb_val;
      default: fwd_mux = reg_val;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_alu_ctl.sv
// ALU control decode: maps the ALU op class and R-type funct field to the
// 3-bit ALU control code. Purely combinational.
module ex_stage_alu_ctl
  import ex_stage_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl
);

  always_comb begin
    alu_ctl = ALU_ADD;
    case (aluop)
      ALUOP_ADD:  alu_ctl = ALU_ADD;
      ALUOP_SUB:  alu_ctl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctl = ALU_ADD;
          FUNCT_SUB: alu_ctl = ALU_SUB;
          FUNCT_AND: alu_ctl = ALU_AND;
          FUNCT_OR:  alu_ctl = ALU_OR;
          FUNCT_SLT: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_ADD;
        endcase
      end
      ALUOP_RSVD: alu_ctl = ALU_ADD;
      default:    alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch target adder, destination mux and the EX/MEM
// latch with stall/flush. Define EX_FWD_EN to add operand forwarding ports.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        regdst,
  input  logic        alusrc,
  input  logic [1:0]  aluop,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
`ifdef EX_FWD_EN
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
`endif
  output logic        out_valid,
  output logic [1:0]  wb_ctlout,
  output logic [2:0]  m_ctlout,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  muxout
);

  logic [2:0]  alu_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b_reg;
  logic [31:0] op_b;
  logic [31:0] alu_d;
  logic [31:0] target_d;
  logic [4:0]  dest_d;

  ex_stage_alu_ctl alu_ctl_dec (
    .aluop   (aluop),
    .funct   (s_extend[5:0]),
    .alu_ctl (alu_ctl)
  );

`ifdef EX_FWD_EN
  assign op_a     = fwd_mux(fwd_a, rdata1, mem_fwd_data, wb_fwd_data);
  assign op_b_reg = fwd_mux(fwd_b, rdata2, mem_fwd_data, wb_fwd_data);
`else
  assign op_a     = rdata1;
  assign op_b_reg = rdata2;
`endif

  assign op_b     = alusrc ? s_extend : op_b_reg;
  assign target_d = npc + (s_extend << 2);
  assign dest_d   = regdst ? instr_1511 : instr_2016;

  always_comb begin
    alu_d = op_a + op_b;
    case (alu_ctl)
      ALU_ADD: alu_d = op_a + op_b;
      ALU_SUB: alu_d = op_a - op_b;
      ALU_AND: alu_d = op_a & op_b;
      ALU_OR:  alu_d = op_a | op_b;
      ALU_SLT: alu_d = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      default: alu_d = op_a + op_b;
    endcase
  end

  // Flush outranks stall so a squashed slot never survives a hold.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid  <= 1'b0;
      wb_ctlout  <= 2'b0;
      m_ctlout   <= 3'b0;
      add_result <= 32'd0;
      zero       <= 1'b0;
      alu_result <= 32'd0;
      rdata2out  <= 32'd0;
      muxout     <= 5'd0;
    end else if (!stall) begin
      out_valid  <= in_valid;
      wb_ctlout  <= in_valid ? wb_ctl : 2'b0;
      m_ctlout   <= in_valid ? m_ctl : 3'b0;
      add_result <= target_d;
      zero       <= (alu_d == 32'd0);
      alu_result <= alu_d;
      rdata2out  <= op_b_reg;
      muxout     <= dest_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; forwarding scenarios are
// exercised when EX_FWD_EN is defined.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npc;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] s_extend;
  logic [4:0]  instr_2016;
  logic [4:0]  instr_1511;
`ifdef EX_FWD_EN
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [31:0] mem_fwd_data;
  logic [31:0] wb_fwd_data;
`endif
  logic        out_valid;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  muxout;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .wb_ctl       (wb_ctl),
    .m_ctl        (m_ctl),
    .regdst       (regdst),
    .alusrc       (alusrc),
    .aluop        (aluop),
    .npc          (npc),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .s_extend     (s_extend),
    .instr_2016   (instr_2016),
    .instr_1511   (instr_1511),
`ifdef EX_FWD_EN
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_fwd_data (mem_fwd_data),
    .wb_fwd_data  (wb_fwd_data),
`endif
    .out_valid    (out_valid),
    .wb_ctlout    (wb_ctlout),
    .m_ctlout     (m_ctlout),
    .add_result   (add_result),
    .zero         (zero),
    .alu_result   (alu_result),
    .rdata2out    (rdata2out),
    .muxout       (muxout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] wb, input logic [2:0] m,
                        input logic rd, input logic src, input logic [1:0] op,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rdf);
    in_valid = v; wb_ctl = wb; m_ctl = m; regdst = rd; alusrc = src; aluop = op;
    npc = pc; rdata1 = a; rdata2 = b; s_extend = imm; instr_2016 = rt; instr_1511 = rdf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(1'b1, 2'b11, 3'b111, 1'b1, 1'b0, 2'b10, 32'h40, 32'd3, 32'd4, 32'h20, 5'd1, 5'd2);
    tick(); tick();
    checks++;
    if ({out_valid, wb_ctlout, m_ctlout, zero, muxout} !== 12'd0 ||
        alu_result !== 32'd0 || add_result !== 32'd0 || rdata2out !== 32'd0) begin
      errors++;
      $display("FAIL reset: valid=%b wb=%b m=%b zero=%b mux=%0d alu=%h add=%h rd2=%h, required all 0",
               out_valid, wb_ctlout, m_ctlout, zero, muxout, alu_result, add_result, rdata2out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype_add();
    set_in(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3);
    tick();
    checks++;
    if (alu_result !== 32'd12 || muxout !== 5'd3 || zero !== 1'b0 || out_valid !== 1'b1 ||
        wb_ctlout !== 2'b10 || rdata2out !== 32'd7 || add_result !== 32'h80) begin
      errors++;
      $display("FAIL rtype_add: alu=%0d mux=%0d zero=%b valid=%b wb=%b rd2=%0d add=%h, required 12 3 0 1 10 7 80",
               alu_result, muxout, zero, out_valid, wb_ctlout, rdata2out, add_result);
    end
  endtask

  task automatic test_beq();
    set_in(1'b1, 2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h100, 32'h1234, 32'h1234, 32'd4, 5'd5, 5'd7);
    tick();
    checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1 || add_result !== 32'h110 ||
        m_ctlout !== 3'b100 || muxout !== 5'd5) begin
      errors++;
      $display("FAIL beq: alu=%h zero=%b add=%h m=%b mux=%0d, required 0 1 110 100 5",
               alu_result, zero, add_result, m_ctlout, muxout);
    end
  endtask

  task automatic test_slt();
    set_in(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd0, 5'd8);
    tick();
    checks++;
    if (alu_result !== 32'd1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_neg: alu=%h zero=%b, required 1 0", alu_result, zero);
    end
    rdata1 = 32'd1; rdata2 = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL slt_swap: alu=%h zero=%b, required 0 1", alu_result, zero);
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  fn  [6] = '{6'h24, 6'h25, 6'h22, 6'h00, 6'h20, 6'h2A};
    logic [31:0] exp [6] = '{32'h0000_00F0, 32'h0000_FFF0, 32'h0000_E100,
                             32'h0001_00E0, 32'h0001_00E0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0000_F0F0, 32'h0000_0FF0,
             {26'd0, fn[i]}, 5'd0, 5'd4);
      tick();
      checks++;
      if (alu_result !== exp[i]) begin
        errors++;
        $display("FAIL alu_funct_%h: alu=%h, required %h", fn[i], alu_result, exp[i]);
      end
    end
    // lw-style address add using the immediate
    set_in(1'b1, 2'b11, 3'b010, 1'b0, 1'b1, 2'b00, 32'h0, 32'h1000, 32'hDEAD, 32'h10, 5'd6, 5'd0);
    tick();
    checks++;
    if (alu_result !== 32'h1010 || muxout !== 5'd6 || rdata2out !== 32'hDEAD || m_ctlout !== 3'b010) begin
      errors++;
      $display("FAIL alusrc_add: alu=%h mux=%0d rd2=%h m=%b, required 1010 6 dead 010",
               alu_result, muxout, rdata2out, m_ctlout);
    end
    aluop = 2'b11; alusrc = 1'b0; rdata2 = 32'h5;
    tick();
    checks++;
    if (alu_result !== 32'h1005) begin
      errors++;
      $display("FAIL aluop_rsvd: alu=%h, required 1005", alu_result);
    end
    set_in(1'b1, 2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h10, 32'd1, 32'd2, 32'hC000_0001, 5'd0, 5'd0);
    tick();
    checks++;
    if (add_result !== 32'h14 || alu_result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
      errors++;
      $display("FAIL target_upper: add=%h alu=%h zero=%b, required 14 ffffffff 0",
               add_result, alu_result, zero);
    end
    npc = 32'h100; s_extend = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (add_result !== 32'hFC) begin
      errors++;
      $display("FAIL target_neg: add=%h, required fc", add_result);
    end
  endtask

  task automatic test_invalid();
    set_in(1'b0, 2'b11, 3'b111, 1'b1, 1'b0, 2'b10, 32'h0, 32'd2, 32'd3, 32'h20, 5'd0, 5'd11);
    tick();
    checks++;
    if (out_valid !== 1'b0 || wb_ctlout !== 2'b00 || m_ctlout !== 3'b000 ||
        alu_result !== 32'd5 || muxout !== 5'd11) begin
      errors++;
      $display("FAIL invalid_slot: valid=%b wb=%b m=%b alu=%0d mux=%0d, required 0 00 000 5 11",
               out_valid, wb_ctlout, m_ctlout, alu_result, muxout);
    end
  endtask

  task automatic test_stall_flush();
    set_in(1'b1, 2'b10, 3'b001, 1'b1, 1'b0, 2'b10, 32'h200, 32'd20, 32'd22, 32'h20, 5'd1, 5'd17);
    tick();
    set_in(1'b1, 2'b01, 3'b010, 1'b0, 1'b0, 2'b01, 32'h0, 32'd9, 32'd9, 32'h0, 5'd2, 5'd3);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || wb_ctlout !== 2'b10 || m_ctlout !== 3'b001 || alu_result !== 32'd42 ||
          muxout !== 5'd17 || rdata2out !== 32'd22 || add_result !== 32'h280 || zero !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b wb=%b m=%b alu=%0d mux=%0d rd2=%0d add=%h zero=%b, required 1 10 001 42 17 22 280 0",
                 i, out_valid, wb_ctlout, m_ctlout, alu_result, muxout, rdata2out, add_result, zero);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || wb_ctlout !== 2'b00 || m_ctlout !== 3'b000 || alu_result !== 32'd0) begin
      errors++;
      $display("FAIL flush_over_stall: valid=%b wb=%b m=%b alu=%h, required 0 00 000 0",
               out_valid, wb_ctlout, m_ctlout, alu_result);
    end
    flush = 1'b0; stall = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || wb_ctlout !== 2'b01 || m_ctlout !== 3'b010 || zero !== 1'b1 || muxout !== 5'd2) begin
      errors++;
      $display("FAIL after_flush: valid=%b wb=%b m=%b zero=%b mux=%0d, required 1 01 010 1 2",
               out_valid, wb_ctlout, m_ctlout, zero, muxout);
    end
  endtask

  task automatic test_reset_midstream();
    set_in(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd100, 32'd23, 32'h22, 5'd0, 5'd12);
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || wb_ctlout !== 2'b00 || alu_result !== 32'd0 || muxout !== 5'd0 || add_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b wb=%b alu=%h mux=%0d add=%h, required all 0",
               out_valid, wb_ctlout, alu_result, muxout, add_result);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || wb_ctlout !== 2'b10 || alu_result !== 32'd77 || muxout !== 5'd12 || add_result !== 32'h88) begin
      errors++;
      $display("FAIL reset_release: valid=%b wb=%b alu=%0d mux=%0d add=%h, required 1 10 77 12 88",
               out_valid, wb_ctlout, alu_result, muxout, add_result);
    end
  endtask

`ifdef EX_FWD_EN
  task automatic test_forwarding();
    set_in(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd1, 32'd2, 32'h20, 5'd0, 5'd5);
    mem_fwd_data = 32'd40; wb_fwd_data = 32'd9;
    fwd_a = 2'b10; fwd_b = 2'b00;
    tick();
    checks++;
    if (alu_result !== 32'd42 || rdata2out !== 32'd2) begin
      errors++;
      $display("FAIL fwd_a_mem: alu=%0d rd2=%0d, required 42 2", alu_result, rdata2out);
    end
    fwd_b = 2'b01;
    tick();
    checks++;
    if (alu_result !== 32'd49 || rdata2out !== 32'd9) begin
      errors++;
      $display("FAIL fwd_b_wb: alu=%0d rd2=%0d, required 49 9", alu_result, rdata2out);
    end
    fwd_a = 2'b11; fwd_b = 2'b11;
    tick();
    checks++;
    if (alu_result !== 32'd3 || rdata2out !== 32'd2) begin
      errors++;
      $display("FAIL fwd_code11: alu=%0d rd2=%0d, required 3 2", alu_result, rdata2out);
    end
    fwd_a = 2'b01; fwd_b = 2'b10; alusrc = 1'b1; s_extend = 32'h20;
    tick();
    checks++;
    if (alu_result !== 32'd41 || rdata2out !== 32'd40) begin
      errors++;
      $display("FAIL fwd_alusrc: alu=%0d rd2=%0d, required 41 40", alu_result, rdata2out);
    end
    fwd_a = 2'b00; fwd_b = 2'b00;
  endtask
`endif

  initial begin
`ifdef EX_FWD_EN
    fwd_a = 2'b00; fwd_b = 2'b00; mem_fwd_data = 32'd0; wb_fwd_data = 32'd0;
`endif
    test_reset();
    test_rtype_add();
    test_beq();
    test_slt();
    test_alu_ops();
    test_invalid();
    test_stall_flush();
    test_reset_midstream();
`ifdef EX_FWD_EN
    test_forwarding();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
